// File: rtl/cache_fill_arbiter_if.sv
// Miss-request, memory-read and cache-fill signals shared by the fill arbiter and its environment.
// The arbiter connects through the slave modport; caches and memory connect through the master modport.
interface cache_fill_arbiter_if;
  logic        i_miss;
  logic [15:0] i_miss_addr;
  logic        d_miss;
  logic [15:0] d_miss_addr;
  logic        mem_data_valid;
  logic [15:0] mem_data;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        i_fill_we;
  logic        d_fill_we;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        i_tag_we;
  logic        d_tag_we;
  logic        i_stall;
  logic        d_stall;
  logic        busy;

  modport slave (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_valid, mem_data,
    output mem_en, mem_addr, i_fill_we, d_fill_we, fill_word, fill_data,
    output i_tag_we, d_tag_we, i_stall, d_stall, busy
  );

  modport master (
    output i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_valid, mem_data,
    input  mem_en, mem_addr, i_fill_we, d_fill_we, fill_word, fill_data,
    input  i_tag_we, d_tag_we, i_stall, d_stall, busy
  );
endinterface

// File: rtl/cache_fill_arbiter.sv
// Arbitrates I/D cache misses onto one pipelined memory and streams an 8-word block into the winner.
// Define CACHE_FILL_FAIRNESS_EN to let I win after two consecutive D grants taken while I waits.
module cache_fill_arbiter (
  input logic                 clk,
  input logic                 rst,
  cache_fill_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FILL, WRAP} state_e;

  state_e      state_q, state_d;
  logic        ownerIsD_q, ownerIsD_d;
  logic [15:0] base_q, base_d;
  logic [3:0]  issueCnt_q, issueCnt_d;
  logic [2:0]  rxCnt_q, rxCnt_d;
  logic        grantD;
  logic        grantAny;
  logic        memEn;
  logic        fillWe;
  logic        tagWe;
  logic        busy;

`ifdef CACHE_FILL_FAIRNESS_EN
  logic [1:0]  fairCnt_q, fairCnt_d;

  assign grantD = bus.d_miss && !(bus.i_miss && (fairCnt_q == 2'd2));
`else
  assign grantD = bus.d_miss;
`endif

  assign grantAny = bus.d_miss || bus.i_miss;

  always_comb begin
    state_d    = state_q;
    ownerIsD_d = ownerIsD_q;
    base_d     = base_q;
    issueCnt_d = issueCnt_q;
    rxCnt_d    = rxCnt_q;
`ifdef CACHE_FILL_FAIRNESS_EN
    fairCnt_d  = fairCnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (grantAny) begin
          state_d    = FILL;
          ownerIsD_d = grantD;
          base_d     = (grantD ? bus.d_miss_addr : bus.i_miss_addr) & 16'hFFF0;
          issueCnt_d = 4'd0;
          rxCnt_d    = 3'd0;
`ifdef CACHE_FILL_FAIRNESS_EN
          fairCnt_d  = (grantD && bus.i_miss) ? fairCnt_q + 2'd1 : 2'd0;
`endif
        end
      end
      FILL: begin
        if (!issueCnt_q[3]) issueCnt_d = issueCnt_q + 4'd1;
        if (bus.mem_data_valid) begin
          rxCnt_d = rxCnt_q + 3'd1;
          if (rxCnt_q == 3'd7) state_d = WRAP;
        end
      end
      WRAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ownerIsD_q <= 1'b1;
      base_q     <= 16'h0000;
      issueCnt_q <= 4'd0;
      rxCnt_q    <= 3'd0;
`ifdef CACHE_FILL_FAIRNESS_EN
      fairCnt_q  <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      ownerIsD_q <= ownerIsD_d;
      base_q     <= base_d;
      issueCnt_q <= issueCnt_d;
      rxCnt_q    <= rxCnt_d;
`ifdef CACHE_FILL_FAIRNESS_EN
      fairCnt_q  <= fairCnt_d;
`endif
    end
  end

  // Outputs decode from registered state; rst masks them so a block abandoned mid-fill never strobes.
  assign busy   = (state_q != IDLE) && !rst;
  assign memEn  = (state_q == FILL) && !issueCnt_q[3] && !rst;
  assign fillWe = (state_q == FILL) && bus.mem_data_valid && !rst;
  assign tagWe  = (state_q == WRAP) && !rst;

  assign bus.busy      = busy;
  assign bus.mem_en    = memEn;
  assign bus.mem_addr  = memEn ? base_q + {12'b0, issueCnt_q[2:0], 1'b0} : 16'h0000;
  assign bus.i_fill_we = fillWe && !ownerIsD_q;
  assign bus.d_fill_we = fillWe && ownerIsD_q;
  assign bus.fill_word = fillWe ? rxCnt_q : 3'd0;
  assign bus.fill_data = fillWe ? bus.mem_data : 16'h0000;
  assign bus.i_tag_we  = tagWe && !ownerIsD_q;
  assign bus.d_tag_we  = tagWe && ownerIsD_q;
  assign bus.i_stall   = bus.i_miss || (busy && !ownerIsD_q);
  assign bus.d_stall   = bus.d_miss || (busy && ownerIsD_q);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with a 4-cycle pipelined memory model returning 16'hA000 + word index.
module tb_cache_fill_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic iMissNow = 1'b0;
  logic dMissNow = 1'b0;
  logic injV = 1'b0;
  logic [3:0]       pipeV = '0;
  logic [3:0][15:0] pipeD = '0;

  always #5 clk = ~clk;

  cache_fill_arbiter_if bus();

  cache_fill_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(posedge clk) begin
    pipeV <= {pipeV[2:0], bus.mem_en};
    pipeD <= {pipeD[2:0], 16'hA000 + {13'b0, bus.mem_addr[3:1]}};
  end

  assign bus.mem_data_valid = pipeV[3] | injV;
  assign bus.mem_data       = pipeV[3] ? pipeD[3] : 16'hBEEF;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic iMiss, input logic [15:0] iAddr,
                               input logic dMiss, input logic [15:0] dAddr);
    iMissNow        = iMiss;
    dMissNow        = dMiss;
    bus.i_miss      = iMiss;
    bus.i_miss_addr = iAddr;
    bus.d_miss      = dMiss;
    bus.d_miss_addr = dAddr;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, " busy"},      bus.busy,      16'h0);
    checkOutput({name, " mem_en"},    bus.mem_en,    16'h0);
    checkOutput({name, " mem_addr"},  bus.mem_addr,  16'h0);
    checkOutput({name, " i_fill_we"}, bus.i_fill_we, 16'h0);
    checkOutput({name, " d_fill_we"}, bus.d_fill_we, 16'h0);
    checkOutput({name, " fill_word"}, bus.fill_word, 16'h0);
    checkOutput({name, " fill_data"}, bus.fill_data, 16'h0);
    checkOutput({name, " i_tag_we"},  bus.i_tag_we,  16'h0);
    checkOutput({name, " d_tag_we"},  bus.d_tag_we,  16'h0);
    checkOutput({name, " i_stall"},   bus.i_stall,   iMissNow);
    checkOutput({name, " d_stall"},   bus.d_stall,   dMissNow);
  endtask

  // Cycles k=1..lastK after a grant; owner address is corrupted from k=2 to k=11 to prove it was latched.
  task automatic runFill(input string name, input bit ownerD, input logic [15:0] addr,
                         input logic [15:0] base, input int relCycle, input bit dropBoth,
                         input int abortAt, input int lastK);
    for (int k = 1; k <= lastK; k++) begin
      bit          live;
      bit          expMemEn, expWe, expTag, expBusy;
      logic [15:0] expAddr, expWord, expData;
      string       t;
      nextCycle();
      if (k == relCycle) begin
        if (ownerD || dropBoth) dMissNow = 1'b0;
        if (!ownerD || dropBoth) iMissNow = 1'b0;
        bus.i_miss = iMissNow;
        bus.d_miss = dMissNow;
      end
      if (k == 2) begin
        if (ownerD) bus.d_miss_addr = 16'hFFFF;
        else        bus.i_miss_addr = 16'hFFFF;
      end
      if (k == 12) begin
        if (ownerD) bus.d_miss_addr = addr;
        else        bus.i_miss_addr = addr;
      end
      if (abortAt != 0 && k == abortAt)     rst = 1'b1;
      if (abortAt != 0 && k == abortAt + 1) rst = 1'b0;
      #1;
      live     = (abortAt == 0) || (k < abortAt);
      expMemEn = live && (k <= 8);
      expAddr  = expMemEn ? base + 16'(2 * (k - 1)) : 16'h0;
      expWe    = live && (k >= 5) && (k <= 12);
      expWord  = expWe ? 16'(k - 5) : 16'h0;
      expData  = expWe ? 16'hA000 + 16'(k - 5) : 16'h0;
      expTag   = live && (k == 13);
      expBusy  = live && (k <= 13);
      t = $sformatf("%s k=%0d", name, k);
      checkOutput({t, " mem_en"},    bus.mem_en,    expMemEn);
      checkOutput({t, " mem_addr"},  bus.mem_addr,  expAddr);
      checkOutput({t, " owner_we"},  ownerD ? bus.d_fill_we : bus.i_fill_we, expWe);
      checkOutput({t, " other_we"},  ownerD ? bus.i_fill_we : bus.d_fill_we, 16'h0);
      checkOutput({t, " fill_word"}, bus.fill_word, expWord);
      checkOutput({t, " fill_data"}, bus.fill_data, expData);
      checkOutput({t, " owner_tag"}, ownerD ? bus.d_tag_we : bus.i_tag_we, expTag);
      checkOutput({t, " other_tag"}, ownerD ? bus.i_tag_we : bus.d_tag_we, 16'h0);
      checkOutput({t, " busy"},      bus.busy,      expBusy);
      checkOutput({t, " i_stall"},   bus.i_stall,   iMissNow | (expBusy & !ownerD));
      checkOutput({t, " d_stall"},   bus.d_stall,   dMissNow | (expBusy & ownerD));
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    rst = 1'b1;
    nextCycle();
    applyStimulus(1'b1, 16'h0040, 1'b0, 16'h0);
    #1;
    checkIdle("reset0");
    nextCycle();
    #1;
    checkIdle("reset1");
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    #1;
    checkIdle("post-reset");

    $display("[TB] D fill from 16'h1234");
    nextCycle();
    applyStimulus(1'b0, 16'h0, 1'b1, 16'h1234);
    #1;
    checkIdle("dfill grant");
    runFill("dfill", 1'b1, 16'h1234, 16'h1230, 13, 1'b0, 0, 14);

    $display("[TB] spurious valid in IDLE");
    nextCycle();
    injV = 1'b1;
    #1;
    checkIdle("spurious0");
    nextCycle();
    #1;
    checkIdle("spurious1");
    nextCycle();
    injV = 1'b0;
    #1;
    checkIdle("spurious2");

    $display("[TB] simultaneous I and D misses");
    nextCycle();
    applyStimulus(1'b1, 16'h4567, 1'b1, 16'h1234);
    #1;
    checkIdle("both grant");
    runFill("both-d", 1'b1, 16'h1234, 16'h1230, 13, 1'b0, 0, 14);
    runFill("both-i", 1'b0, 16'h4567, 16'h4560, 13, 1'b0, 0, 14);

    $display("[TB] I miss dropped at T+3");
    nextCycle();
    applyStimulus(1'b1, 16'h0ABC, 1'b0, 16'h0);
    #1;
    checkIdle("idrop grant");
    runFill("idrop", 1'b0, 16'h0ABC, 16'h0AB0, 3, 1'b0, 0, 14);

    $display("[TB] reset at T+7 of a D fill");
    nextCycle();
    applyStimulus(1'b0, 16'h0, 1'b1, 16'h5678);
    #1;
    checkIdle("abort grant");
    runFill("abort", 1'b1, 16'h5678, 16'h5670, 1, 1'b0, 7, 16);

    $display("[TB] arbitration with I held and D re-asserted");
    nextCycle();
    applyStimulus(1'b1, 16'h3008, 1'b1, 16'h2004);
    #1;
    checkIdle("fair grant");
    runFill("fair1", 1'b1, 16'h2004, 16'h2000, 99, 1'b0, 0, 14);
    runFill("fair2", 1'b1, 16'h2004, 16'h2000, 99, 1'b0, 0, 14);
`ifdef CACHE_FILL_FAIRNESS_EN
    runFill("fair3", 1'b0, 16'h3008, 16'h3000, 13, 1'b1, 0, 14);
`else
    runFill("fair3", 1'b1, 16'h2004, 16'h2000, 13, 1'b1, 0, 14);
`endif
    nextCycle();
    #1;
    checkIdle("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_fill_arbiter.md
CACHE_FILL_ARBITER -- requirements
Module: cache_fill_arbiter

Interface
REQ-001 SHALL provide clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL provide rst, input, 1, synchronous active-high reset.
REQ-003 SHALL provide i_miss, input, 1, I-cache miss for the current fetch; i_miss_addr, input, 16, the miss byte address.
REQ-004 SHALL provide d_miss, input, 1, D-cache miss for the current access; d_miss_addr, input, 16, the miss byte address.
REQ-005 SHALL provide mem_data_valid, input, 1, and mem_data, input, 16, the read-data return from the shared memory.
REQ-006 SHALL provide mem_en, output, 1, and mem_addr, output, 16, the read request to the shared memory.
REQ-007 SHALL provide i_fill_we and d_fill_we, output, 1 each, data-array word write strobes; fill_word, output, 3, word index; fill_data, output, 16.
REQ-008 SHALL provide i_tag_we and d_tag_we, output, 1 each, tag/valid write strobes.
REQ-009 SHALL provide i_stall and d_stall, output, 1 each, pipeline stall requests; d_stall drives the pipeline-register d_cache_miss inputs.
REQ-010 SHALL provide busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-011 The memory SHALL be treated as pipelined: one address per cycle, data returned exactly 4 cycles after mem_en, in issue order.
REQ-012 Block = 8 words (16 bytes); base = miss_addr & 16'hFFF0, latched at grant.
REQ-013 FSM states SHALL be IDLE, FILL, WRAP.
REQ-014 IDLE: d_miss high -> grant D; else i_miss high -> grant I; go to FILL next cycle; owner latched. Neither high -> stay IDLE.
REQ-015 FILL: mem_en SHALL assert for 8 consecutive cycles starting the first FILL cycle; mem_addr = base + 2*issue_cnt (issue_cnt 0..7).
REQ-016 FILL: each mem_data_valid cycle SHALL pulse the owner's fill_we with fill_word = rx_cnt and fill_data = mem_data; rx_cnt increments.
REQ-017 The 8th valid word (rx_cnt 7) SHALL move FILL -> WRAP next cycle.
REQ-018 WRAP: owner's tag_we SHALL pulse for one cycle; next state IDLE.
REQ-019 Grant at cycle T: mem_en T+1..T+8, fill_we T+5..T+12, tag_we T+13, IDLE T+14.
REQ-020 i_stall = i_miss OR (busy AND owner==I); d_stall = d_miss OR (busy AND owner==D).
REQ-021 mem_data_valid in IDLE or WRAP SHALL be ignored (no strobes, no counter change).
REQ-022 A miss of the non-owner during a fill SHALL be held off (stall stays high) and arbitrated in the IDLE cycle after WRAP.
REQ-023 Owner miss deassertion mid-FILL SHALL NOT abort the fill.
REQ-024 Non-owner strobes SHALL remain 0 at all times.
REQ-025 i_miss_addr/d_miss_addr changes after grant SHALL NOT affect mem_addr.

Reset
REQ-026 rst SHALL force state IDLE, issue_cnt=0, rx_cnt=0, owner=D, fairness counter=0.
REQ-027 During rst and the cycle after: mem_en, all fill_we, all tag_we, busy = 0; mem_addr, fill_word, fill_data = 0; stalls follow REQ-020 with busy=0.
REQ-028 rst mid-fill SHALL abandon the block with no tag_we; in-flight returns then arrive in IDLE and are ignored per REQ-021.

Configuration
REQ-029 Macro CACHE_FILL_FAIRNESS_EN SHALL select the arbitration policy.
REQ-030 Defined: a 2-bit counter counts consecutive D grants while i_miss is high; at 2, the next IDLE grant with i_miss high goes to I; counter clears on any I grant or when i_miss is low at grant.
REQ-031 Undefined: strict D priority per REQ-014; no counter logic.

Verification
REQ-032 d_miss=1, addr 16'h1234, mem returns 16'hA000+k -> mem_addr 16'h1230..16'h123E, d_fill_we words 0..7 with A000..A007, d_tag_we at T+13, busy low at T+14.
REQ-033 i_miss and d_miss both high in same IDLE cycle -> D filled first; i_stall held high throughout; I grant in IDLE cycle after WRAP (T+14), I fill follows.
REQ-034 rst asserted at T+7 of a D fill -> next cycle IDLE, no d_tag_we, late valids ignored, mem_en low.
REQ-035 Spurious mem_data_valid in IDLE -> no fill_we, no tag_we, state unchanged.
REQ-036 With CACHE_FILL_FAIRNESS_EN, i_miss held and d_miss re-asserted each IDLE -> grants D, D, I; without -> D indefinitely.
REQ-037 Owner miss dropped at T+3 -> full 8-word fill and tag_we still complete.
